// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// FSM state encoding, default base address, wait-counter width.
package dmem_pkg;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
  localparam int          CNT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Word index relative to the base, 32-bit unsigned wrap.
  function automatic logic [29:0] word_index(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    logic [31:0] d;
    d = addr - base;
    return d[31:2];
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM, DEPTH_WORDS x 32, no reset.
// Ports: clk, i_we/i_re enables, i_addr word index, i_wdata, o_rdata (registered).
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory target for the multicycle core.
// Ports: clk, rst (async high), MemRead/MemWrite/dAddress/dWriteData in;
// dReadData, dReady (1-cycle pulse), dErr out. Macro: DMEM_ERR_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        dReady,
  output logic        dErr
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_wr;
  logic             r_err;
  logic             r_have;

  logic        w_req;
  logic        w_idle;
  logic        w_accept;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_wr;
  logic [29:0] w_index;
  logic        w_acc_err;
  logic        w_enter_resp;
  logic        w_we;
  logic        w_re;
  logic [31:0] w_q;

  assign w_req    = MemRead | MemWrite;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle & w_req;

  // With zero wait states the commit edge is also the accept edge,
  // so the live request is used instead of the latches.
  assign w_addr  = w_idle ? dAddress   : r_addr;
  assign w_wdata = w_idle ? dWriteData : r_wdata;
  assign w_wr    = w_idle ? MemWrite   : r_wr;
  assign w_index = word_index(w_addr, BASE_ADDR);

`ifdef DMEM_ERR_CHECK_EN
  assign w_acc_err = (w_addr[1:0] != 2'b00) |
                     ({2'b00, w_index} >= 32'(DEPTH_WORDS));
`else
  logic w_unused;
  assign w_unused  = ^{w_index, w_addr[1:0]};
  assign w_acc_err = 1'b0;
`endif

  assign w_enter_resp =
    (w_accept && (WAIT_CYCLES == 0)) ||
    ((r_state == ST_WAIT) && (r_cnt == CNT_ONE));

  assign w_we = w_enter_resp & w_wr & ~w_acc_err;
  assign w_re = w_enter_resp & ~w_wr & ~w_acc_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_addr (w_index[AW-1:0]),
    .i_wdata(w_wdata),
    .o_rdata(w_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_have  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr  <= dAddress;
            r_wdata <= dWriteData;
            r_wr    <= MemWrite;
            r_err   <= w_acc_err;
            r_cnt   <= WAIT_INIT;
            r_state <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= ST_RESP;
        end
        ST_RESP: r_state <= ST_RELEASE;
        ST_RELEASE: begin
          if (!w_req) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_re) r_have <= 1'b1;
    end
  end

  // RAM output has no reset; mask it until a read has completed.
  assign dReadData = r_have ? w_q : 32'h0;
  assign dReady    = (r_state == ST_RESP);
  assign dErr      = (r_state == ST_RESP) & r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder.
// Instance A uses 2 wait states, instance B uses none.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [31:0] OOR  = BASE + 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_rd = 1'b0, a_wr = 1'b0;
  logic [31:0] a_addr = '0, a_wd = '0, a_rdata;
  logic        a_rdy, a_err;
  logic        b_rd = 1'b0, b_wr = 1'b0;
  logic [31:0] b_addr = '0, b_wd = '0, b_rdata;
  logic        b_rdy, b_err;

  int n_cmp = 0;
  int n_bad = 0;

  int          lat, pl;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(2)) u_a (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (a_rd),
    .MemWrite  (a_wr),
    .dAddress  (a_addr),
    .dWriteData(a_wd),
    .dReadData (a_rdata),
    .dReady    (a_rdy),
    .dErr      (a_err)
  );

  dmem_responder #(.WAIT_CYCLES(0)) u_b (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (b_rd),
    .MemWrite  (b_wr),
    .dAddress  (b_addr),
    .dWriteData(b_wd),
    .dReadData (b_rdata),
    .dReady    (b_rdy),
    .dErr      (b_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic r, input logic w,
                       input logic [31:0] ad, input logic [31:0] wd);
    if (sel) begin
      b_rd = r; b_wr = w; b_addr = ad; b_wd = wd;
    end else begin
      a_rd = r; a_wr = w; a_addr = ad; a_wd = wd;
    end
  endtask

  task automatic access(input bit sel, input logic r, input logic w,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input int hold,
                        output int o_lat, output logic [31:0] o_rd,
                        output logic o_err, output int o_pl);
    logic rdy;
    @(negedge clk);
    drive(sel, r, w, ad, wd);
    o_lat = -1; o_pl = 0; o_rd = 'x; o_err = 1'bx;
    for (int i = 1; i <= 20 && o_lat < 0; i++) begin
      @(posedge clk); #1;
      rdy = sel ? b_rdy : a_rdy;
      if (rdy) begin
        o_lat = i; o_pl = 1;
        o_rd  = sel ? b_rdata : a_rdata;
        o_err = sel ? b_err : a_err;
      end
    end
    if (o_lat < 0) begin
      n_cmp++; n_bad++;
      $error("FAIL timeout: observed no dReady expected pulse");
    end
    for (int i = 0; i <= hold; i++) begin
      @(posedge clk); #1;
      rdy = sel ? b_rdy : a_rdy;
      if (rdy) o_pl++;
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_rdy", 32'(a_rdy), 32'd0);
    check("rst_a_err", 32'(a_err), 32'd0);
    check("rst_a_data", a_rdata, 32'h0);
    check("rst_b_rdy", 32'(b_rdy), 32'd0);
    check("rst_b_err", 32'(b_err), 32'd0);
    check("rst_b_data", b_rdata, 32'h0);
    @(negedge clk) rst = 1'b0;

    access(0, 1'b0, 1'b1, BASE, 32'h1111_1111, 0, lat, rd, er, pl);
    check("w0_lat", 32'(lat), 32'd3);
    check("w0_err", 32'(er), 32'd0);

    // Start a write and reset it while it sits in WAIT.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, BASE, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_rdy", 32'(a_rdy), 32'd0);
    check("midrst_err", 32'(a_err), 32'd0);
    check("midrst_data", a_rdata, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk) rst = 1'b0;
    access(0, 1'b1, 1'b0, BASE, 32'h0, 0, lat, rd, er, pl);
    check("discard_data", rd, 32'h1111_1111);
    check("discard_lat", 32'(lat), 32'd3);

    access(0, 1'b0, 1'b1, 32'h1001_0008, 32'hCAFE_F00D, 0, lat, rd, er, pl);
    check("w8_lat", 32'(lat), 32'd3);
    check("w8_err", 32'(er), 32'd0);
    check("w8_pulses", 32'(pl), 32'd1);
    access(0, 1'b1, 1'b0, 32'h1001_0008, 32'h0, 0, lat, rd, er, pl);
    check("r8_lat", 32'(lat), 32'd3);
    check("r8_data", rd, 32'hCAFE_F00D);
    check("r8_err", 32'(er), 32'd0);
    check("r8_pulses", 32'(pl), 32'd1);

    access(0, 1'b1, 1'b1, 32'h1001_0010, 32'h1234_5678, 0, lat, rd, er, pl);
    check("both_lat", 32'(lat), 32'd3);
    check("both_keep", rd, 32'hCAFE_F00D);
    access(0, 1'b1, 1'b0, 32'h1001_0010, 32'h0, 0, lat, rd, er, pl);
    check("both_data", rd, 32'h1234_5678);

    access(1, 1'b0, 1'b1, 32'h1001_0004, 32'h0BAD_CAFE, 0, lat, rd, er, pl);
    check("b_w_lat", 32'(lat), 32'd1);
    access(1, 1'b1, 1'b0, 32'h1001_0004, 32'h0, 4, lat, rd, er, pl);
    check("b_r_lat", 32'(lat), 32'd1);
    check("b_r_data", rd, 32'h0BAD_CAFE);
    check("b_hold_pulses", 32'(pl), 32'd1);

`ifdef DMEM_ERR_CHECK_EN
    access(0, 1'b0, 1'b1, 32'h1001_0002, 32'h7777_7777, 0, lat, rd, er, pl);
    check("mis_err", 32'(er), 32'd1);
    check("mis_lat", 32'(lat), 32'd3);
    access(0, 1'b1, 1'b0, BASE, 32'h0, 0, lat, rd, er, pl);
    check("mis_unchanged", rd, 32'h1111_1111);
    check("mis_rd_err", 32'(er), 32'd0);
    access(0, 1'b1, 1'b0, OOR, 32'h0, 0, lat, rd, er, pl);
    check("oor_err", 32'(er), 32'd1);
    check("oor_hold", rd, 32'h1111_1111);
    check("oor_lat", 32'(lat), 32'd3);
`else
    access(0, 1'b0, 1'b1, OOR, 32'hA5A5_A5A5, 0, lat, rd, er, pl);
    check("wrap_w_err", 32'(er), 32'd0);
    access(0, 1'b1, 1'b0, BASE, 32'h0, 0, lat, rd, er, pl);
    check("wrap_data", rd, 32'hA5A5_A5A5);
    check("wrap_r_err", 32'(er), 32'd0);
    access(0, 1'b1, 1'b0, 32'h1001_000B, 32'h0, 0, lat, rd, er, pl);
    check("lowbits_data", rd, 32'hCAFE_F00D);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
